// File: rtl/req_arb_pkg.sv
// rtl/req_arb_pkg.sv - shared types and constants for the three-way request arbiter
package req_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   // Grant codes match the downstream datapath select encoding.
   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_A    = 2'd1;
   localparam logic [1:0] GNT_B    = 2'd2;
   localparam logic [1:0] GNT_C    = 2'd3;

   localparam int REQ_A = 0;
   localparam int REQ_B = 1;
   localparam int REQ_C = 2;

   function automatic logic [2:0] code_to_onehot(input logic [1:0] code);
      logic [2:0] oh;
      oh = 3'b000;
      case (code)
         GNT_A:   oh[REQ_A] = 1'b1;
         GNT_B:   oh[REQ_B] = 1'b1;
         GNT_C:   oh[REQ_C] = 1'b1;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner selection, round-robin after ptr or fixed A>B>C
module rr_pick
   import req_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   input  logic       rr_en,
   output logic [2:0] win,
   output logic [1:0] win_code
);

   logic [1:0] start;

   // start selects the search order: 0 = A,B,C  1 = B,C,A  2 = C,A,B
   always_comb begin
      start = 2'd0;
      if (rr_en && ptr == GNT_A)
         start = 2'd1;
      else if (rr_en && ptr == GNT_B)
         start = 2'd2;
   end

   always_comb begin
      win_code = GNT_NONE;
      case (start)
         2'd1: begin
            if (req[REQ_B])      win_code = GNT_B;
            else if (req[REQ_C]) win_code = GNT_C;
            else if (req[REQ_A]) win_code = GNT_A;
         end
         2'd2: begin
            if (req[REQ_C])      win_code = GNT_C;
            else if (req[REQ_A]) win_code = GNT_A;
            else if (req[REQ_B]) win_code = GNT_B;
         end
         default: begin
            if (req[REQ_A])      win_code = GNT_A;
            else if (req[REQ_B]) win_code = GNT_B;
            else if (req[REQ_C]) win_code = GNT_C;
         end
      endcase
      win = code_to_onehot(win_code);
   end

endmodule

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - fair, time-bounded arbiter for three requesters sharing one register slot
module req_arbiter
   import req_arb_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int RR_EN    = 1,
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        req,
   input  logic [2:0]        done,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   input  logic [DATA_W-1:0] c_data,
   output logic [2:0]        gnt,
   output logic [1:0]        gnt_code,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              timeout
);

   arb_state_t        state;
   logic [1:0]        ptr;
   logic [CNT_W-1:0]  hold_cnt;
   logic [2:0]        pick_win;
   logic [1:0]        pick_code;
   logic              owner_req;
   logic              owner_done;
   logic              at_limit;
   logic [DATA_W-1:0] owner_data;

   rr_pick u_pick (
      .req      (req),
      .ptr      (ptr),
      .rr_en    (RR_EN != 0),
      .win      (pick_win),
      .win_code (pick_code)
   );

   // gnt is the registered one-hot owner, so masking with it ignores non-owners.
   assign owner_req  = |(req & gnt);
   assign owner_done = |(done & gnt);
   assign at_limit   = (hold_cnt == CNT_W'(HOLD_MAX));

   always_comb begin
      owner_data = '0;
      case (gnt_code)
         GNT_A:   owner_data = a_data;
         GNT_B:   owner_data = b_data;
         GNT_C:   owner_data = c_data;
         default: owner_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= 3'b000;
         gnt_code   <= GNT_NONE;
         data_out   <= '0;
         data_valid <= 1'b0;
         timeout    <= 1'b0;
         hold_cnt   <= '0;
         ptr        <= GNT_C;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state    <= GRANT;
                  gnt      <= pick_win;
                  gnt_code <= pick_code;
                  hold_cnt <= CNT_W'(1);
               end
            end
            GRANT: begin
               if (!owner_req || owner_done || at_limit) begin
                  state      <= RELEASE;
                  gnt        <= 3'b000;
                  gnt_code   <= GNT_NONE;
                  data_valid <= 1'b0;
                  ptr        <= gnt_code;
                  // Only a release forced purely by the hold limit counts as a timeout.
                  timeout    <= at_limit && owner_req && !owner_done;
               end else begin
                  hold_cnt   <= hold_cnt + CNT_W'(1);
                  data_out   <= owner_data;
                  data_valid <= 1'b1;
               end
            end
            RELEASE: begin
               state    <= IDLE;
               hold_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(gnt) && (gnt == code_to_onehot(gnt_code)));

endmodule
